// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
// Round-robin front end sharing one sequential shift-add multiplier among NREQ requesters.
// Response arrives one cycle after done is seen in WAIT; there is no response backpressure and at most one request is accepted per operation.
module mult_share_arbiter #(
   parameter  int NREQ    = 4,
   parameter  int WIDTH   = 4,
   parameter  int TIMEOUT = 32,
   localparam int IDW     = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]    rsp_product,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  mul_clear,
   output logic                  mul_start,
   output logic [WIDTH-1:0]      mul_multiplicand,
   output logic [WIDTH-1:0]      mul_multiplier,
   input  logic [2*WIDTH-1:0]    mul_product,
   input  logic                  mul_done
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  grant;
   logic [IDW-1:0]  cand;
   logic            grant_vld;
   logic [CW-1:0]   wdog;
   logic            accept;

   // First valid requester after the last winner, wrapping modulo NREQ.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(ptr) + k) % NREQ);
         if (!grant_vld && req_valid[cand]) begin
            grant     = cand;
            grant_vld = 1'b1;
         end
      end
   end

   assign accept = (state == IDLE) && grant_vld;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = CLEAR;
         CLEAR:   state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT:    if (mul_done || (wdog == CW'(TIMEOUT - 1))) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr              <= IDW'(NREQ - 1);
         rsp_valid        <= 1'b0;
         rsp_id           <= '0;
         rsp_product      <= '0;
         rsp_err          <= 1'b0;
         mul_clear        <= 1'b0;
         mul_start        <= 1'b0;
         mul_multiplicand <= '0;
         mul_multiplier   <= '0;
         wdog             <= '0;
      end else begin
         mul_clear <= (state_nxt == CLEAR);
         mul_start <= (state_nxt == START);
         rsp_valid <= (state_nxt == RESP);
         if (accept) begin
            ptr              <= grant;
            rsp_id           <= grant;
            mul_multiplicand <= req_a[int'(grant)*WIDTH +: WIDTH];
            mul_multiplier   <= req_b[int'(grant)*WIDTH +: WIDTH];
         end
         if (state == START) wdog <= '0;
         // Done takes priority over the watchdog expiring in the same cycle.
         if (state == WAIT) begin
            if (mul_done) begin
               rsp_product <= mul_product;
               rsp_err     <= 1'b0;
            end else if (wdog == CW'(TIMEOUT - 1)) begin
               rsp_product <= '0;
               rsp_err     <= 1'b1;
            end else begin
               wdog <= wdog + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mult_share_arbiter with a latency-programmable multiplier stub.
module tb_mult_share_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 4;
   localparam int TIMEOUT = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [15:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_product;
   logic        rsp_err;
   logic        busy;
   logic        mul_clear, mul_start;
   logic [3:0]  mul_multiplicand, mul_multiplier;
   logic [7:0]  mul_product;
   logic        mul_done;

   // Multiplier stub state
   logic        done_r = 1'b0;
   logic [7:0]  prod_r = '0;
   logic        pend = 1'b0;
   int          cnt = 0;
   int          lat = 1;
   bit          dead = 1'b0;
   bit          stale_done = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mul_done    = done_r | stale_done;
   assign mul_product = prod_r;

   always @(posedge clk) begin
      if (mul_clear) begin
         done_r <= 1'b0;
         prod_r <= '0;
         pend   <= 1'b0;
      end else if (mul_start) begin
         pend <= !dead;
         cnt  <= lat;
      end else if (pend) begin
         if (cnt == 1) begin
            done_r <= 1'b1;
            prod_r <= 8'(mul_multiplicand) * 8'(mul_multiplier);
            pend   <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
      .busy(busy), .mul_clear(mul_clear), .mul_start(mul_start),
      .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
      .mul_product(mul_product), .mul_done(mul_done)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [15:0] a;
      logic [15:0] b;
      int          lat;
      bit          dead;
      bit          stale;
      int          exp_id;
      logic [7:0]  exp_prod;
      bit          exp_err;
      int          exp_cyc;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Starts at cycle 0 (IDLE, just after a rising edge); returns at the IDLE cycle after RESP.
   task automatic apply(input vec_t v);
      int  id;
      int  rc;
      bit  got;
      id         = v.exp_id;
      req_valid  = v.vld;
      req_a      = v.a;
      req_b      = v.b;
      lat        = v.lat;
      dead       = v.dead;
      stale_done = v.stale;
      @(negedge clk);
      chk("grant", {28'd0, req_ready}, 32'(1) << id);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_rsp", {31'd0, rsp_valid}, 0);
      @(posedge clk); #1;
      req_a = ~v.a;
      req_b = ~v.b;
      @(negedge clk);
      chk("clear_pulse", {30'd0, mul_clear, mul_start}, 32'b10);
      chk("busy", {31'd0, busy}, 1);
      chk("opa", {28'd0, mul_multiplicand}, {28'd0, v.a[id*4 +: 4]});
      chk("opb", {28'd0, mul_multiplier}, {28'd0, v.b[id*4 +: 4]});
      @(negedge clk);
      chk("start_pulse", {30'd0, mul_clear, mul_start}, 32'b01);
      @(posedge clk); #1;
      stale_done = 1'b0;
      got = 1'b0;
      rc  = 0;
      for (int c = 3; c <= 3 + TIMEOUT + 5 && !got; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            rc  = c;
         end else begin
            chk("ready_while_busy", {28'd0, req_ready}, 0);
         end
      end
      if (!got) begin
         chk("rsp_timeout", 0, 1);
      end else begin
         chk("rsp_cycle", rc, v.exp_cyc);
         chk("rsp_id", {30'd0, rsp_id}, id);
         chk("rsp_product", {24'd0, rsp_product}, {24'd0, v.exp_prod});
         chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      vec_t rv;
      //           vld      a         b         lat dead stale id prod    err cyc
      vecs[0]  = '{4'b0001, 16'h0004, 16'h0003, 1,  0,   0,    0, 8'd12,  0,  5};
      vecs[1]  = '{4'b1110, 16'h2F70, 16'h5F90, 2,  0,   0,    1, 8'd63,  0,  6};
      vecs[2]  = '{4'b1100, 16'h2F70, 16'h5F90, 4,  0,   0,    2, 8'd225, 0,  8};
      vecs[3]  = '{4'b1000, 16'h2F70, 16'h5F90, 1,  0,   0,    3, 8'd10,  0,  5};
      vecs[4]  = '{4'b1001, 16'h8003, 16'h7005, 3,  0,   0,    0, 8'd15,  0,  7};
      vecs[5]  = '{4'b1001, 16'h8003, 16'h7005, 3,  0,   0,    3, 8'd56,  0,  7};
      vecs[6]  = '{4'b1001, 16'h8003, 16'h7005, 3,  0,   0,    0, 8'd15,  0,  7};
      vecs[7]  = '{4'b1001, 16'h8003, 16'h7005, 3,  0,   0,    3, 8'd56,  0,  7};
      vecs[8]  = '{4'b0100, 16'h0500, 16'h0500, 1,  1,   0,    2, 8'd0,   1,  35};
      vecs[9]  = '{4'b0011, 16'h0096, 16'h0097, 2,  0,   0,    0, 8'd42,  0,  6};
      vecs[10] = '{4'b0010, 16'h0030, 16'h00B0, 31, 0,   0,    1, 8'd33,  0,  35};
      vecs[11] = '{4'b0100, 16'h0900, 16'h0800, 3,  0,   1,    2, 8'd72,  0,  7};
      vecs[12] = '{4'b0001, 16'h0000, 16'h000F, 1,  0,   0,    0, 8'd0,   0,  5};

      reset     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      @(negedge clk);
      chk("reset_outs", {rsp_valid, rsp_err, mul_clear, mul_start, busy, req_ready}, 0);
      chk("reset_data", {rsp_id, rsp_product, mul_multiplicand, mul_multiplier}, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) apply(vecs[i]);

      // Reset during WAIT: requester 2 is in flight and must be dropped.
      req_valid = 4'b0100;
      req_a     = 16'h0500;
      req_b     = 16'h0600;
      dead      = 1'b1;
      @(negedge clk);
      chk("rst_grant", {28'd0, req_ready}, 32'b0100);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (5) @(negedge clk);
      chk("rst_in_wait", {30'd0, busy, rsp_valid}, 32'b10);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("midrst_outs", {rsp_valid, rsp_err, mul_clear, mul_start, busy, req_ready}, 0);
      chk("midrst_data", {rsp_id, rsp_product, mul_multiplicand, mul_multiplier}, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_norsp", {31'd0, rsp_valid}, 0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      dead  = 1'b0;
      // Pointer must be back at NREQ-1, so requester 0 beats requester 3.
      rv = '{4'b1001, 16'h0004, 16'h0003, 1, 0, 0, 0, 8'd12, 0, 5};
      apply(rv);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one sequential 4-bit shift-add multiplier (`RTL_multiply`: `start`/`done` handshake, sticky `done`, active-high `reset`) among NREQ requesters. It accepts one operand pair at a time, clears and starts the multiplier, waits for `done` under a watchdog, and returns the 8-bit product tagged with the requester index. It sits between requester logic and a single `RTL_multiply` instance and drives that instance's `reset`, `start` and operand ports.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 4: operand width; the product is 2*WIDTH bits.
- TIMEOUT, 32: maximum WAIT cycles before aborting an operation (≥ 2).
- IDW: localparam, $clog2(NREQ).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*WIDTH  multiplicand; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  multiplier, same packing as req_a.
- req_ready  out  NREQ  one-hot accept strobe (combinational).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_product  out  2*WIDTH  product; 0 on error.
- rsp_err  out  1  watchdog expired; valid only with rsp_valid.
- busy  out  1  high in every state except IDLE.
- mul_clear  out  1  drives the multiplier `reset` (active-high, one-cycle pulse).
- mul_start  out  1  drives the multiplier `start` (one-cycle pulse).
- mul_multiplicand  out  WIDTH  latched operand A.
- mul_multiplier  out  WIDTH  latched operand B.
- mul_product  in  2*WIDTH  multiplier `product`.
- mul_done  in  1  multiplier `done` (sticky until cleared).

## Operation
- **States:** IDLE → CLEAR → START → WAIT → RESP → IDLE.
- **IDLE:**
  - If any req_valid is high, select the first valid requester searching from ptr+1, wrapping modulo NREQ.
  - Drive req_ready[g]=1 combinationally in that cycle only.
  - At the clock edge: latch req_a[g] and req_b[g] into the operand registers, latch g into the id register, set ptr←g, go to CLEAR.
- **CLEAR:** mul_clear=1 for one cycle. This flushes the sticky `done` and the previous product. Go to START.
- **START:** mul_start=1 for one cycle. Reset the watchdog counter to 0. Go to WAIT.
- **WAIT:**
  - If mul_done=1: latch mul_product, clear the error flag, go to RESP.
  - Else if counter==TIMEOUT-1: set the product register to 0, set the error flag, go to RESP.
  - Else: counter+1.
- **RESP:** rsp_valid=1 with registered rsp_id, rsp_product and rsp_err. Go to IDLE unconditionally; there is no backpressure on the response.
- mul_done is ignored outside WAIT, including a stale high value during CLEAR or START.
- req_valid of a requester that is not granted is ignored. That requester holds its request; the arbiter does not queue it.
- req_a and req_b are sampled only on the accept edge. Later changes do not affect the operation in flight.
- Requester g has lowest priority in the next arbitration. This is strict rotation: no requester waits more than NREQ-1 operations.
- Operand registers hold their value after the operation until the next accept.
- **Width rules:**
  - Operands are unsigned.
  - The product passes through at 2*WIDTH bits with no truncation (15*15=225 fits in 8 bits).
  - The watchdog counter is $clog2(TIMEOUT) bits wide.

## Timing
- **Reset (reset=0, asynchronous):**
  - State=IDLE; ptr=NREQ-1, so requester 0 wins first.
  - Registered outputs clear to 0: rsp_valid, rsp_id, rsp_product, rsp_err, mul_clear, mul_start, mul_multiplicand, mul_multiplier.
  - Combinational outputs are forced by the IDLE reset state: busy=0; req_ready=0 while no req_valid is high.
  - Reset deassertion is synchronised by the caller.
- **Reset mid-operation:** the in-flight request is dropped and no response is issued. The requester must re-present it. The multiplier is reset by its system reset, not by this block.
- **Cycle numbering:** accept edge at the end of cycle 0 (IDLE). mul_clear high in cycle 1, mul_start high in cycle 2, WAIT from cycle 3.
- **Latency:** if mul_done is first sampled high in cycle w, rsp_valid is high in cycle w+1.
- **Throughput:** minimum of 1 IDLE cycle between RESP and the next accept. The earliest next req_ready is the cycle after RESP.
- **Timeout:** with no done, WAIT lasts exactly TIMEOUT cycles. rsp_valid with rsp_err=1 appears in cycle 3+TIMEOUT.
- **Simultaneous events:** if mul_done=1 in the same cycle the counter reaches TIMEOUT-1, done wins and rsp_err=0.

## Test plan
- **Single request:** Reset, then requester 0 presents a=4, b=3. Expect req_ready[0] for one cycle, mul_clear then mul_start in consecutive cycles, rsp_valid one cycle after done with rsp_id=0, rsp_product=12, rsp_err=0.
- **Simultaneous requests:** Requesters 1, 2 and 3 assert valid together with (7,9), (15,15) and (2,5). Expect grant order 1, 2, 3 and responses 63, 225, 10 with matching rsp_id. No acceptance while busy=1.
- **Rotation and wrap-around:** Requesters 0 and 3 are held valid continuously. Expect grants alternating 0, 3, 0, 3 across the wrap from index 3 back to 0.
- **Watchdog:** Stub mul_done stuck at 0, TIMEOUT=32, requester 2 presents (5,5). Expect rsp_valid in cycle 35 after accept with rsp_err=1, rsp_product=0, rsp_id=2. The next request then completes normally.
- **Stale done:** Hold mul_done high through CLEAR and START. Expect it ignored: WAIT is entered and the response uses the product sampled when done is seen in WAIT.
- **Reset mid-operation:** Assert reset=0 during WAIT. Expect all outputs 0 immediately and no rsp_valid. After release, requester 0 re-requests (4,3) and gets 12.
